// File: rtl/instr_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module      : instr_fetch_unit
// Description : Instruction sequencer for the 16-bit core. Holds the PC,
//               addresses the synchronous instruction ROM, latches the
//               returned word onto the core's DIN, pulses run, and waits for
//               done before fetching the next word.
// Revision    : 1.0 - initial release
// ============================================================================
module instr_fetch_unit #(
  parameter int ADDR_W     = 5,
  parameter int DATA_W     = 16,
  parameter int MEM_LAT    = 1,
  parameter int START_ADDR = 0,
  parameter int LAST_ADDR  = 31,
  parameter int WRAP       = 0
) (
  input  logic              clock,
  input  logic              resetN,
  input  logic              enable,
  input  logic              done,
  input  logic              pc_load,
  input  logic [ADDR_W-1:0] pc_load_value,
  input  logic [DATA_W-1:0] mem_q,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] instr,
  output logic              run,
  output logic              busy,
  output logic              halted,
  output logic [15:0]       retired
);

  localparam logic [ADDR_W-1:0] c_START    = ADDR_W'(START_ADDR);
  localparam logic [ADDR_W-1:0] c_LAST     = ADDR_W'(LAST_ADDR);
  localparam logic [ADDR_W-1:0] c_PC_STEP  = ADDR_W'(1);
  // Latency counter only needs to reach MEM_LAT-1 (at most 2).
  localparam logic [1:0]        c_LAT_LAST = 2'(MEM_LAT - 1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_ISSUE  = 3'd2,
    S_EXEC   = 3'd3,
    S_HALTED = 3'd4
  } state_t;

  state_t            r_state;
  logic [ADDR_W-1:0] r_pc;
  logic [1:0]        r_lat_cnt;
  logic [DATA_W-1:0] r_instr;
  logic              r_run;
  logic              r_busy;
  logic              r_halted;
  logic [15:0]       r_retired;

  logic [ADDR_W-1:0] w_next_pc;
  logic              w_halt;

  // Next PC on instruction completion: jump, wrap to start, or sequential step.
  always_comb begin
    w_next_pc = r_pc + c_PC_STEP;
    w_halt    = 1'b0;
    if (pc_load) begin
      w_next_pc = pc_load_value;
    end else if (r_pc == c_LAST) begin
      if (WRAP != 0) begin
        w_next_pc = c_START;
      end else begin
        w_halt    = 1'b1;
      end
    end
  end

  // Sequencer FSM; all outputs are registered alongside the state.
  always_ff @(posedge clock or negedge resetN) begin
    if (!resetN) begin
      r_state   <= S_IDLE;
      r_pc      <= c_START;
      r_lat_cnt <= 2'd0;
      r_instr   <= '0;
      r_run     <= 1'b0;
      r_busy    <= 1'b0;
      r_halted  <= 1'b0;
      r_retired <= 16'd0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (enable) begin
            r_state   <= S_FETCH;
            r_lat_cnt <= 2'd0;
            r_busy    <= 1'b1;
          end
        end
        S_FETCH: begin
          // PC is frozen here, so the ROM address is stable for the whole wait.
          r_lat_cnt <= r_lat_cnt + 2'd1;
          if (r_lat_cnt == c_LAT_LAST) begin
            r_instr <= mem_q;
            r_run   <= 1'b1;
            r_state <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          // done is deliberately not looked at: it may still be high from the
          // previous instruction.
          r_run   <= 1'b0;
          r_state <= S_EXEC;
        end
        S_EXEC: begin
          if (done) begin
            r_retired <= r_retired + 16'd1;
            if (w_halt) begin
              r_state  <= S_HALTED;
              r_busy   <= 1'b0;
              r_halted <= 1'b1;
            end else begin
              r_pc <= w_next_pc;
              if (enable) begin
                r_state   <= S_FETCH;
                r_lat_cnt <= 2'd0;
              end else begin
                r_state <= S_IDLE;
                r_busy  <= 1'b0;
              end
            end
          end
        end
        S_HALTED: begin
          r_run    <= 1'b0;
          r_busy   <= 1'b0;
          r_halted <= 1'b1;
        end
        default: begin
          r_state  <= S_IDLE;
          r_run    <= 1'b0;
          r_busy   <= 1'b0;
          r_halted <= 1'b0;
        end
      endcase
    end
  end

  assign mem_addr = r_pc;
  assign instr    = r_instr;
  assign run      = r_run;
  assign busy     = r_busy;
  assign halted   = r_halted;
  assign retired  = r_retired;

endmodule
`default_nettype wire

// File: tb/tb_instr_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_instr_fetch_unit
// Description : Self-checking bench for instr_fetch_unit. Instance A uses
//               MEM_LAT=1, LAST_ADDR=3, halting; instance B uses MEM_LAT=2,
//               LAST_ADDR=3, wrapping. Issued words are checked against a
//               scoreboard of expected {address, word} pairs.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_instr_fetch_unit;

  logic        clock = 1'b0;
  logic        resetN = 1'b0;

  logic        en_a = 1'b0, done_a = 1'b0, pl_a = 1'b0;
  logic [4:0]  plv_a = 5'd0;
  logic [15:0] q_a;
  logic [4:0]  addr_a;
  logic [15:0] instr_a, retired_a;
  logic        run_a, busy_a, halted_a;

  logic        en_b = 1'b0, done_b = 1'b0;
  logic        pl_b = 1'b0;
  logic [4:0]  plv_b = 5'd0;
  logic [15:0] q_b;
  logic [4:0]  addr_b;
  logic [15:0] instr_b, retired_b;
  logic        run_b, busy_b, halted_b;

  logic [15:0] rom [32];
  logic [20:0] exp_a [$];
  logic [20:0] exp_b [$];

  int checks = 0, errors = 0;
  int cyc = 0;
  int nrun_a = 0, nrun_b = 0;
  int last_a = -1, last_b = -1;
  logic chk_per_a = 1'b0, chk_per_b = 1'b0;
  logic auto_a = 1'b0, auto_b = 1'b0, hold_b = 1'b0;
  logic seen_a = 1'b0, seen_b = 1'b0;
  logic jump_on = 1'b0;
  int   jidx = 0;
  logic [4:0] jfrom [2];
  logic [4:0] jto   [2];

  instr_fetch_unit #(.ADDR_W(5), .DATA_W(16), .MEM_LAT(1), .START_ADDR(0),
                     .LAST_ADDR(3), .WRAP(0)) u_dut_a (
    .clock(clock), .resetN(resetN), .enable(en_a), .done(done_a),
    .pc_load(pl_a), .pc_load_value(plv_a), .mem_q(q_a), .mem_addr(addr_a),
    .instr(instr_a), .run(run_a), .busy(busy_a), .halted(halted_a),
    .retired(retired_a));

  instr_fetch_unit #(.ADDR_W(5), .DATA_W(16), .MEM_LAT(2), .START_ADDR(0),
                     .LAST_ADDR(3), .WRAP(1)) u_dut_b (
    .clock(clock), .resetN(resetN), .enable(en_b), .done(done_b),
    .pc_load(pl_b), .pc_load_value(plv_b), .mem_q(q_b), .mem_addr(addr_b),
    .instr(instr_b), .run(run_b), .busy(busy_b), .halted(halted_b),
    .retired(retired_b));

  always #5 clock = ~clock;

  // ROM data follows the PC; the address is held stable throughout FETCH.
  assign q_a = rom[addr_a];
  assign q_b = rom[addr_b];

  always @(posedge clock) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic push_a(input int a);
    exp_a.push_back({a[4:0], rom[a]});
  endtask

  task automatic push_b(input int a);
    exp_b.push_back({a[4:0], rom[a]});
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(negedge clock);
      #1;
    end
  endtask

  task automatic wait_runs_a(input int n);
    int k = 0;
    while (nrun_a < n && k < 300) begin tick(1); k++; end
    chk("wait_runs_a", 32'(nrun_a >= n), 32'd1);
  endtask

  task automatic wait_runs_b(input int n);
    int k = 0;
    while (nrun_b < n && k < 300) begin tick(1); k++; end
    chk("wait_runs_b", 32'(nrun_b >= n), 32'd1);
  endtask

  task automatic wait_halt_a();
    int k = 0;
    while (halted_a !== 1'b1 && k < 300) begin tick(1); k++; end
    chk("wait_halt_a", 32'(halted_a), 32'd1);
  endtask

  // Core model: done one cycle after run; pc_load is noise unless a jump is due.
  always @(negedge clock) begin
    if (!jump_on) jidx = 0;
    if (auto_a && seen_a) begin
      done_a = 1'b1;
      if (jump_on && jidx < 2 && addr_a == jfrom[jidx]) begin
        pl_a  = 1'b1;
        plv_a = jto[jidx];
        jidx  = jidx + 1;
      end else begin
        pl_a  = 1'b0;
        plv_a = 5'd9;
      end
    end else begin
      done_a = 1'b0;
      pl_a   = 1'b1;
      plv_a  = 5'd9;
    end
    seen_a = (run_a === 1'b1);
    done_b = auto_b ? seen_b : hold_b;
    seen_b = (run_b === 1'b1);
  end

  // Scoreboard: every run pulse must match the next expected {addr, word}.
  always @(negedge clock) begin
    logic [20:0] e;
    if (run_a === 1'b1) begin
      nrun_a++;
      chk("sb_a_expected_run", 32'(exp_a.size() != 0), 32'd1);
      if (exp_a.size() != 0) begin
        e = exp_a.pop_front();
        chk("sb_a_addr_instr", 32'({addr_a, instr_a}), 32'(e));
      end
      if (chk_per_a && last_a >= 0) chk("period_a", 32'(cyc - last_a), 32'd3);
      last_a = cyc;
    end
    if (!chk_per_a) last_a = -1;
    if (run_b === 1'b1) begin
      nrun_b++;
      chk("sb_b_expected_run", 32'(exp_b.size() != 0), 32'd1);
      if (exp_b.size() != 0) begin
        e = exp_b.pop_front();
        chk("sb_b_addr_instr", 32'({addr_b, instr_b}), 32'(e));
      end
      if (chk_per_b && last_b >= 0) chk("period_b", 32'(cyc - last_b), 32'd4);
      last_b = cyc;
    end
    if (!chk_per_b) last_b = -1;
  end

  initial begin
    int base;
    for (int i = 0; i < 32; i++) rom[i] = 16'hA001 + 16'(i);
    rom[17] = 16'hB017;
    rom[30] = 16'hC030;
    jfrom[0] = 5'd2; jto[0] = 5'd17;
    jfrom[1] = 5'd3; jto[1] = 5'd30;

    // Reset state
    tick(3);
    chk("rst_run_a", 32'(run_a), 32'd0);
    chk("rst_busy_a", 32'(busy_a), 32'd0);
    chk("rst_halted_a", 32'(halted_a), 32'd0);
    chk("rst_instr_a", 32'(instr_a), 32'd0);
    chk("rst_retired_a", 32'(retired_a), 32'd0);
    chk("rst_addr_a", 32'(addr_a), 32'd0);
    chk("rst_busy_b", 32'(busy_b), 32'd0);

    // Straight-line program, halts after the word at LAST_ADDR
    for (int i = 0; i < 4; i++) push_a(i);
    resetN = 1'b1; en_a = 1'b1; auto_a = 1'b1; chk_per_a = 1'b1;
    wait_halt_a();
    chk("halt_retired_a", 32'(retired_a), 32'd4);
    chk("halt_addr_a", 32'(addr_a), 32'd3);
    chk("halt_busy_a", 32'(busy_a), 32'd0);
    chk("halt_instr_a", 32'(instr_a), 32'hA004);
    tick(20);
    chk("halt_no_run_a", 32'(nrun_a), 32'd4);
    chk("halt_stays_a", 32'(halted_a), 32'd1);

    // Jumps: 2->17, then at LAST_ADDR 3->30 (jump wins over halt)
    en_a = 1'b0; chk_per_a = 1'b0; resetN = 1'b0;
    tick(2);
    for (int i = 0; i < 3; i++) push_a(i);
    for (int i = 17; i < 32; i++) push_a(i);
    for (int i = 0; i < 4; i++) push_a(i);
    push_a(30); push_a(31);
    for (int i = 0; i < 4; i++) push_a(i);
    jump_on = 1'b1; resetN = 1'b1; en_a = 1'b1; chk_per_a = 1'b1;
    wait_halt_a();
    chk("jump_retired_a", 32'(retired_a), 32'd28);
    chk("jump_addr_a", 32'(addr_a), 32'd3);
    chk("jump_runs_a", 32'(nrun_a), 32'd32);
    jump_on = 1'b0;

    // Enable dropped during FETCH of pc=1
    en_a = 1'b0; chk_per_a = 1'b0; resetN = 1'b0;
    tick(2);
    for (int i = 0; i < 4; i++) push_a(i);
    base = nrun_a;
    resetN = 1'b1; en_a = 1'b1;
    wait_runs_a(base + 1);
    tick(2);
    chk("drop_fetch_addr_a", 32'(addr_a), 32'd1);
    en_a = 1'b0;
    tick(8);
    chk("drop_idle_busy_a", 32'(busy_a), 32'd0);
    chk("drop_idle_halted_a", 32'(halted_a), 32'd0);
    chk("drop_idle_addr_a", 32'(addr_a), 32'd2);
    chk("drop_idle_retired_a", 32'(retired_a), 32'd2);
    chk("drop_idle_runs_a", 32'(nrun_a), 32'(base + 2));
    en_a = 1'b1;
    wait_halt_a();
    chk("resume_retired_a", 32'(retired_a), 32'd4);
    chk("resume_runs_a", 32'(nrun_a), 32'(base + 4));
    en_a = 1'b0;

    // MEM_LAT=2 with wrap: 0,1,2,3,0 at a 4-clock period
    resetN = 1'b0;
    tick(2);
    for (int i = 0; i < 4; i++) push_b(i);
    push_b(0);
    resetN = 1'b1; en_b = 1'b1; auto_b = 1'b1; chk_per_b = 1'b1;
    wait_runs_b(5);
    chk("wrap_run_b", 32'(run_b), 32'd1);
    chk("wrap_retired_b", 32'(retired_b), 32'd4);

    // Asynchronous reset while run is high
    chk_per_b = 1'b0;
    resetN = 1'b0;
    #1;
    chk("arst_run_b", 32'(run_b), 32'd0);
    chk("arst_busy_b", 32'(busy_b), 32'd0);
    chk("arst_addr_b", 32'(addr_b), 32'd0);
    chk("arst_retired_b", 32'(retired_b), 32'd0);
    chk("arst_instr_b", 32'(instr_b), 32'd0);
    en_b = 1'b0; auto_b = 1'b0;

    // done held high: ignored in ISSUE, counted once per EXEC
    hold_b = 1'b1;
    push_b(0); push_b(1);
    tick(2);
    resetN = 1'b1; en_b = 1'b1;
    wait_runs_b(6);
    chk("hold_issue_retired_b", 32'(retired_b), 32'd0);
    tick(1);
    chk("hold_exec_retired_b", 32'(retired_b), 32'd0);
    tick(1);
    chk("hold_next_retired_b", 32'(retired_b), 32'd1);
    chk("hold_next_addr_b", 32'(addr_b), 32'd1);
    en_b = 1'b0;
    tick(8);
    chk("hold_idle_busy_b", 32'(busy_b), 32'd0);
    chk("hold_idle_retired_b", 32'(retired_b), 32'd2);
    chk("hold_idle_addr_b", 32'(addr_b), 32'd2);
    chk("hold_idle_runs_b", 32'(nrun_b), 32'd7);

    chk("sb_a_drained", 32'(exp_a.size()), 32'd0);
    chk("sb_b_drained", 32'(exp_b.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
